// File: rtl/id_issue_stage_if.sv
// id_issue_stage_if: bundles the instruction handshake, the writeback port
// and the registered ALU-side outputs of the decode/issue stage.
//   master : upstream/test side (drives instruction + writeback)
//   slave  : the issue stage itself (drives in_ready and the ALU outputs)
interface id_issue_stage_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          in_valid;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [AW-1:0] issue_rd;
  logic          issue_valid;
  logic          illegal;
  logic [15:0]   stall_cnt;

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data,
    input  in_ready, alu_a, alu_b, alu_op, issue_rd, issue_valid, illegal, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data,
    output in_ready, alu_a, alu_b, alu_op, issue_rd, issue_valid, illegal, stall_cnt
  );
endinterface

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage in front of the registered ALU.
// Decodes opcode/rd/rs1/rs2 from in_instr, reads operands from an internal
// register file (with writeback write-through), interlocks RAW hazards with a
// per-register busy bit, and registers a/b/op/rd toward the ALU.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : id_issue_stage_if.slave (handshake, writeback, ALU outputs, stats)
module id_issue_stage #(
  parameter int NREGS = 16,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  id_issue_stage_if.slave    bus
);

  logic [NREGS-1:0][DW-1:0] rf;
  logic [NREGS-1:0]         busy, busy_nxt;

  logic [3:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  assign op  = bus.in_instr[31:28];
  assign rd  = bus.in_instr[24 +: AW];
  assign rs1 = bus.in_instr[20 +: AW];
  assign rs2 = bus.in_instr[16 +: AW];

  // Low instruction bits carry nothing for this stage.
  logic unused_bits;
  assign unused_bits = ^bus.in_instr[15:0];

  // Opcode classes
  logic use_rs1, use_rs2, wr_rd, op_ill;
  assign use_rs1 = (op >= 4'd1) && (op <= 4'd8);
  assign use_rs2 = (op >= 4'd1) && (op <= 4'd6);
  assign wr_rd   = (op >= 4'd1) && (op <= 4'd9);
  assign op_ill  = (op >= 4'd10);

  // A writeback to a nonzero source this cycle both forwards its data and
  // resolves that source's hazard.
  logic wb_hit1, wb_hit2;
  assign wb_hit1 = bus.wb_en && (bus.wb_addr == rs1) && (rs1 != '0);
  assign wb_hit2 = bus.wb_en && (bus.wb_addr == rs2) && (rs2 != '0);

  logic [DW-1:0] val1, val2;
  assign val1 = (rs1 == '0) ? '0 : (wb_hit1 ? bus.wb_data : rf[rs1]);
  assign val2 = (rs2 == '0) ? '0 : (wb_hit2 ? bus.wb_data : rf[rs2]);

  logic haz1, haz2;
  assign haz1 = use_rs1 && (rs1 != '0) && busy[rs1] && !wb_hit1;
  assign haz2 = use_rs2 && (rs2 != '0) && busy[rs2] && !wb_hit2;

  assign bus.in_ready = !(haz1 || haz2);

  logic accept;
  assign accept = bus.in_valid && bus.in_ready;

  // Clear from writeback first, then set from issue so a same-edge
  // issue to the register being written back leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_en) busy_nxt[bus.wb_addr] = 1'b0;
    if (accept && wr_rd && (rd != '0)) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf   <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (bus.wb_en && (bus.wb_addr != '0)) rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_op      <= '0;
      bus.issue_rd    <= '0;
      bus.issue_valid <= 1'b0;
      bus.illegal     <= 1'b0;
    end else if (accept) begin
      bus.alu_a       <= use_rs1 ? val1 : '0;
      bus.alu_b       <= use_rs2 ? val2 : '0;
      bus.alu_op      <= op_ill ? 4'd0 : op;
      bus.issue_rd    <= rd;
      // NOP and illegal ops both go out as bubbles.
      bus.issue_valid <= wr_rd;
      bus.illegal     <= op_ill;
    end else begin
      bus.alu_op      <= '0;
      bus.issue_valid <= 1'b0;
      bus.illegal     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.stall_cnt <= '0;
    else if (bus.in_valid && !bus.in_ready && (bus.stall_cnt != 16'hFFFF))
      bus.stall_cnt <= bus.stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_issue_stage_if bus();
  id_issue_stage dut (.clk(clk), .rst(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_dp;
    logic [3:0]  op;
    logic        iv;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [31:0] ins(input int op, input int rd, input int rs1, input int rs2);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], 16'hBEEF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.wb_en    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".alu_a"}, bus.alu_a, 0);
    chk({tag, ".alu_b"}, bus.alu_b, 0);
    chk({tag, ".alu_op"}, {28'd0, bus.alu_op}, 0);
    chk({tag, ".issue_rd"}, {28'd0, bus.issue_rd}, 0);
    chk({tag, ".issue_valid"}, {31'd0, bus.issue_valid}, 0);
    chk({tag, ".illegal"}, {31'd0, bus.illegal}, 0);
    chk({tag, ".stall_cnt"}, {16'd0, bus.stall_cnt}, 0);
  endtask

  initial begin
    //          v  instr            we wa wd    rdy dp op iv ill a   b  rd sc
    tbl[0]  = '{1, ins(1,3,0,0),    0, 0, 0,    1,  1, 1, 1, 0,  0,  0, 3, 0};
    tbl[1]  = '{0, 32'd0,           1, 1, 7,    1,  1, 0, 0, 0,  0,  0, 3, 0};
    tbl[2]  = '{0, 32'd0,           1, 2, 5,    1,  1, 0, 0, 0,  0,  0, 3, 0};
    tbl[3]  = '{1, ins(2,4,1,2),    0, 0, 0,    1,  1, 2, 1, 0,  7,  5, 4, 0};
    tbl[4]  = '{1, ins(4,7,3,1),    0, 0, 0,    0,  1, 0, 0, 0,  7,  5, 4, 1};
    tbl[5]  = '{1, ins(4,7,3,1),    1, 3, 11,   1,  1, 4, 1, 0,  11, 7, 7, 1};
    tbl[6]  = '{1, ins(12,5,4,4),   0, 0, 0,    1,  0, 0, 0, 1,  0,  0, 0, 1};
    tbl[7]  = '{1, ins(7,8,5,4),    0, 0, 0,    1,  1, 7, 1, 0,  0,  0, 8, 1};
    tbl[8]  = '{1, ins(9,0,1,2),    0, 0, 0,    1,  1, 9, 1, 0,  0,  0, 0, 1};
    tbl[9]  = '{1, ins(1,2,0,0),    1, 0, 99,   1,  1, 1, 1, 0,  0,  0, 2, 1};
    tbl[10] = '{1, ins(3,10,0,0),   1, 0, 55,   1,  1, 3, 1, 0,  0,  0, 10, 1};
    tbl[11] = '{1, ins(0,11,4,7),   0, 0, 0,    1,  0, 0, 0, 0,  0,  0, 0, 1};
    tbl[12] = '{1, ins(1,6,0,0),    1, 6, 3,    1,  1, 1, 1, 0,  0,  0, 6, 1};
    tbl[13] = '{1, ins(5,12,6,0),   0, 0, 0,    0,  1, 0, 0, 0,  0,  0, 6, 2};

    drive(0, 0, 0, 0, 0);
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].instr, tbl[i].we, tbl[i].wa, tbl[i].wd);
      #1;
      chk($sformatf("v%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.alu_op", i), {28'd0, bus.alu_op}, {28'd0, tbl[i].op});
      chk($sformatf("v%0d.issue_valid", i), {31'd0, bus.issue_valid}, {31'd0, tbl[i].iv});
      chk($sformatf("v%0d.illegal", i), {31'd0, bus.illegal}, {31'd0, tbl[i].ill});
      chk($sformatf("v%0d.stall_cnt", i), {16'd0, bus.stall_cnt}, {16'd0, tbl[i].sc});
      if (tbl[i].chk_dp) begin
        chk($sformatf("v%0d.alu_a", i), bus.alu_a, tbl[i].a);
        chk($sformatf("v%0d.alu_b", i), bus.alu_b, tbl[i].b);
        chk($sformatf("v%0d.issue_rd", i), {28'd0, bus.issue_rd}, {28'd0, tbl[i].rd});
      end
    end

    // Hold the blocked op (rs1=r6 busy) and watch the stall counter climb.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("stall.in_ready", {31'd0, bus.in_ready}, 0);
      @(posedge clk);
      #1;
      chk("stall.stall_cnt", {16'd0, bus.stall_cnt}, 3 + k);
      chk("stall.issue_valid", {31'd0, bus.issue_valid}, 0);
    end

    // Async reset in the middle of the stall, away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset.in_ready", {31'd0, bus.in_ready}, 1);

    // After release the previously blocked op issues at once; r6 was cleared.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post.in_ready", {31'd0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    chk("post.alu_op", {28'd0, bus.alu_op}, 5);
    chk("post.issue_valid", {31'd0, bus.issue_valid}, 1);
    chk("post.alu_a", bus.alu_a, 0);
    chk("post.issue_rd", {28'd0, bus.issue_rd}, 12);
    chk("post.stall_cnt", {16'd0, bus.stall_cnt}, 0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("idle.alu_op", {28'd0, bus.alu_op}, 0);
    chk("idle.issue_rd", {28'd0, bus.issue_rd}, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage that sits directly upstream of the registered ALU stage.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes the 4-bit ALU opcode and register indices.
- Reads operands from an internal register file and drives registered a/b/opcode into the ALU.
- A busy-bit scoreboard, updated by the writeback port, interlocks read-after-write hazards.

Parameters:
- NREGS, 16, register file depth; register index width is log2(NREGS), 4 at default.
- DW, 32, operand and data width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- in_valid  input  1  instruction word present
- in_instr  input  32  instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] ignored
- in_ready  output  1  stage accepts in_instr this cycle (combinational)
- wb_en  input  1  writeback strobe
- wb_addr  input  4  writeback register index
- wb_data  input  DW  writeback value
- alu_a  output  DW  operand A to ALU (registered)
- alu_b  output  DW  operand B to ALU (registered)
- alu_op  output  4  opcode to ALU (registered); 0000 = bubble
- issue_rd  output  4  destination of the issued op (registered)
- issue_valid  output  1  alu_op carries a real op this cycle
- illegal  output  1  pulses 1 cycle after an accepted opcode 1010-1111
- stall_cnt  output  16  saturating count of cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0.
  - register file cleared to 0.
  - all busy bits cleared.
- Opcode classes:
  - 0001-0110 read rs1 and rs2.
  - 0111 and 1000 read rs1 only; alu_b <= 0.
  - 1001 reads nothing; alu_a and alu_b <= 0.
  - 0000 is a NOP: accepted, issues a bubble, and sets no busy bit.
  - 1010-1111 are illegal: accepted; alu_op <= 0000, issue_valid <= 0, illegal <= 1 for one cycle; no busy bit set.
  - Every opcode 0001-1001 writes rd.
- Register read:
  - r0 always reads 0; writes to r0 are discarded and r0 is never marked busy.
  - Write-through: if wb_en=1 and wb_addr equals a source index in the same cycle (and is nonzero), the operand is wb_data.
- Hazard:
  - A source is hazardous if it is used by the opcode, is nonzero, its busy bit is set, and it is not being cleared by wb_en/wb_addr this cycle.
  - in_ready = 0 while any used source is hazardous; otherwise in_ready = 1.
- Accept (in_valid and in_ready at a clock edge):
  - alu_a, alu_b, alu_op, issue_rd and issue_valid load on that edge; latency is 1 cycle from accept to the ALU inputs.
  - busy[rd] is set for opcodes 0001-1001 with rd != 0.
- No accept: alu_op <= 0000, issue_valid <= 0; alu_a, alu_b and issue_rd hold.
- Writeback:
  - wb_en=1 writes regfile[wb_addr] <= wb_data and clears busy[wb_addr].
  - If the same edge both issues to rd=wb_addr and clears it, set wins: the bit stays busy.
- stall_cnt increments each cycle with in_valid=1 and in_ready=0, saturates at 16'hFFFF, and clears only on reset.
- Reset asserted mid-stall or mid-issue: the stage returns immediately to the reset state; pending busy bits are lost.

Test Plan:
- Reset, then accept instr opcode 0001 rd=3 rs1=0 rs2=0 -> next cycle alu_op=0001, alu_a=0, alu_b=0, issue_rd=3, issue_valid=1, busy[3]=1.
- Write r1=7 and r2=5 via wb, then issue 0010 rd=4 rs1=1 rs2=2 -> alu_a=7, alu_b=5, alu_op=0010 one cycle after accept.
- Issue 0001 rd=5, then 0100 rs1=5 -> in_ready=0 and stall_cnt counts up each cycle. Pulse wb_en wb_addr=5 wb_data=9 -> same-cycle accept with alu_a=9.
- Issue opcode 1100 -> accepted, illegal=1 for one cycle, alu_op=0000, issue_valid=0, no busy bit changes.
- Writes to r0 and a source of r0 -> r0 reads 0, never stalls. Same-edge issue rd=6 and wb_addr=6 -> busy[6] remains 1.
- Drop rst to 0 during a stall -> all outputs 0 asynchronously. After release, the previously blocked rs1 issues without stall.
